// File: rtl/maxpool_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// maxpool_ctrl_pkg
// Shared definitions for the 2x2 max-pool sequencer:
//   - FSM state encoding
//   - pool index width (9) and pixel width (8), signed pixel type
//   - out_dim(): output map dimension from an input dimension (odd sizes
//     drop their last row/column)
// ---------------------------------------------------------------------------
package maxpool_ctrl_pkg;

    localparam int IDX_W  = 9;
    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] pix_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD0  = 3'd1;
    localparam logic [2:0] ST_RD1  = 3'd2;
    localparam logic [2:0] ST_RD2  = 3'd3;
    localparam logic [2:0] ST_RD3  = 3'd4;
    localparam logic [2:0] ST_LAST = 3'd5;
    localparam logic [2:0] ST_EMIT = 3'd6;
    localparam logic [2:0] ST_DONE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_RD0  = ST_RD0,
        S_RD1  = ST_RD1,
        S_RD2  = ST_RD2,
        S_RD3  = ST_RD3,
        S_LAST = ST_LAST,
        S_EMIT = ST_EMIT,
        S_DONE = ST_DONE
    } state_t;

    // OUT_W = IN_W/2, OUT_H = IN_H/2 (integer division drops an odd edge).
    function automatic int out_dim(input int in_dim);
        return in_dim / 2;
    endfunction

endpackage

// File: rtl/maxpool_ctrl_if.sv
// ---------------------------------------------------------------------------
// maxpool_ctrl_if
// Bundles the buffer read port and the window beat towards the max-pool
// datapath.
//   master (sequencer): drives rd_en, rd_addr, pool_en, pool_iter,
//                       pool_d0..pool_d3; receives rd_data, out_ready
//   slave  (buffer + datapath): the reverse
// ---------------------------------------------------------------------------
interface maxpool_ctrl_if #(
    parameter int ADDR_W = 10
) ();
    import maxpool_ctrl_pkg::*;

    // buffer read port, data valid the cycle after rd_en
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    pix_t              rd_data;

    // window beat, transfers when pool_en && out_ready
    logic              pool_en;
    logic              out_ready;
    logic [IDX_W-1:0]  pool_iter;
    pix_t              pool_d0;
    pix_t              pool_d1;
    pix_t              pool_d2;
    pix_t              pool_d3;

    modport master (
        output rd_en, rd_addr, pool_en, pool_iter,
               pool_d0, pool_d1, pool_d2, pool_d3,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, pool_en, pool_iter,
               pool_d0, pool_d1, pool_d2, pool_d3,
        output rd_data, out_ready
    );

endinterface

// File: rtl/maxpool_win_addr_gen.sv
// ---------------------------------------------------------------------------
// maxpool_win_addr_gen
// Window walker for the 2x2 max-pool sequencer. Holds the r/c window
// counters, the running output index, the row-base accumulator and the
// four-way pixel offset mux.
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : start of a map; load base_i, zero the counters
//   base_i    : address of pixel (0,0)
//   step_i    : window accepted downstream; advance to the next window
//   sel_i     : pixel within the window (0 TL, 1 TR, 2 BL, 3 BR)
//   addr_o    : read address of pixel sel_i, computed from the counters'
//               next-state values so the parent can register it directly
//   iter_o    : output index r*OUT_W+c of the current window
//   last_o    : current window is the final one of the map
// ---------------------------------------------------------------------------
module maxpool_win_addr_gen
    import maxpool_ctrl_pkg::*;
#(
    parameter int IN_W   = 24,
    parameter int IN_H   = 24,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              step_i,
    input  logic [1:0]        sel_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [IDX_W-1:0]  iter_o,
    output logic              last_o
);

    localparam int OUT_W = out_dim(IN_W);
    localparam int OUT_H = out_dim(IN_H);

    localparam logic [IDX_W-1:0]  C_MAX    = IDX_W'(OUT_W - 1);
    localparam logic [IDX_W-1:0]  R_MAX    = IDX_W'(OUT_H - 1);
    // moving down one window row skips two pixel rows
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IN_W);

    logic [IDX_W-1:0]  c_q, c_d;
    logic [IDX_W-1:0]  r_q, r_d;
    logic [IDX_W-1:0]  iter_q, iter_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] off [4];

    // Pixel offsets inside a window: {0, 1, IN_W, IN_W+1}
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_off
        assign off[gi] = ADDR_W'((gi % 2) + (gi / 2) * IN_W);
    end

    always_comb begin
        c_d        = c_q;
        r_d        = r_q;
        iter_d     = iter_q;
        row_base_d = row_base_q;
        if (clear_i) begin
            c_d        = '0;
            r_d        = '0;
            iter_d     = '0;
            row_base_d = base_i;
        end else if (step_i) begin
            iter_d = iter_q + IDX_W'(1);
            if (c_q == C_MAX) begin
                c_d        = '0;
                r_d        = r_q + IDX_W'(1);
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                c_d = c_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q        <= '0;
            r_q        <= '0;
            iter_q     <= '0;
            row_base_q <= '0;
        end else begin
            c_q        <= c_d;
            r_q        <= r_d;
            iter_q     <= iter_d;
            row_base_q <= row_base_d;
        end
    end

    // All sums wrap naturally modulo 2^ADDR_W.
    assign addr_o = row_base_d + ADDR_W'({c_d, 1'b0}) + off[sel_i];
    assign iter_o = iter_q;
    assign last_o = (r_q == R_MAX) && (c_q == C_MAX);

endmodule

// File: rtl/maxpool_ctrl.sv
// ---------------------------------------------------------------------------
// maxpool_ctrl
// Sequencer for the 2x2 max-pool post-process stage. On start it walks the
// feature map window by window: four reads (TL, TR, BL, BR) through the
// 1-cycle-latency buffer port, then one beat carrying the four pixels and
// the output index, held until out_ready. done pulses once after the last
// beat is accepted.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle request, only honoured in IDLE
//   base_addr  : address of pixel (0,0), latched on start
//   busy       : first read through last accepted beat
//   done       : one-cycle pulse after the final beat
//   bus        : read port + window beat (master side)
// All outputs are registered.
// ---------------------------------------------------------------------------
module maxpool_ctrl
    import maxpool_ctrl_pkg::*;
#(
    parameter int IN_W   = 24,
    parameter int IN_H   = 24,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    maxpool_ctrl_if.master    bus
);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              pool_en_q;
    logic [IDX_W-1:0]  pool_iter_q;
    pix_t              pool_d_q [4];

    logic              gen_clear;
    logic              gen_step;
    logic [1:0]        gen_sel;
    logic [ADDR_W-1:0] gen_addr;
    logic [IDX_W-1:0]  gen_iter;
    logic              gen_last;

    // The generator returns the address for the read issued in the *next*
    // cycle, so select the pixel that follows the current state.
    always_comb begin
        gen_clear = (state_q == S_IDLE) && start;
        gen_step  = (state_q == S_EMIT) && bus.out_ready;
        gen_sel   = 2'd0;
        case (state_q)
            S_RD0:   gen_sel = 2'd1;
            S_RD1:   gen_sel = 2'd2;
            S_RD2:   gen_sel = 2'd3;
            default: gen_sel = 2'd0;
        endcase
    end

    maxpool_win_addr_gen #(
        .IN_W   (IN_W),
        .IN_H   (IN_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear_i (gen_clear),
        .base_i  (base_addr),
        .step_i  (gen_step),
        .sel_i   (gen_sel),
        .addr_o  (gen_addr),
        .iter_o  (gen_iter),
        .last_o  (gen_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pool_en_q   <= 1'b0;
            pool_iter_q <= '0;
            for (int i = 0; i < 4; i++) begin
                pool_d_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RD0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= gen_addr;
                    end
                end
                S_RD0: begin
                    state_q   <= S_RD1;
                    rd_addr_q <= gen_addr;
                end
                // rd_data lags rd_en by one cycle: the pixel read in RDk
                // lands in RD(k+1), the last one in LAST.
                S_RD1: begin
                    pool_d_q[0] <= bus.rd_data;
                    state_q     <= S_RD2;
                    rd_addr_q   <= gen_addr;
                end
                S_RD2: begin
                    pool_d_q[1] <= bus.rd_data;
                    state_q     <= S_RD3;
                    rd_addr_q   <= gen_addr;
                end
                S_RD3: begin
                    pool_d_q[2] <= bus.rd_data;
                    state_q     <= S_LAST;
                    rd_en_q     <= 1'b0;
                end
                S_LAST: begin
                    pool_d_q[3] <= bus.rd_data;
                    pool_iter_q <= gen_iter;
                    pool_en_q   <= 1'b1;
                    state_q     <= S_EMIT;
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        pool_en_q <= 1'b0;
                        if (gen_last) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_RD0;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= gen_addr;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.pool_en   = pool_en_q;
    assign bus.pool_iter = pool_iter_q;
    assign bus.pool_d0   = pool_d_q[0];
    assign bus.pool_d1   = pool_d_q[1];
    assign bus.pool_d2   = pool_d_q[2];
    assign bus.pool_d3   = pool_d_q[3];

endmodule

// File: doc/maxpool_ctrl.md
# maxpool_ctrl

Sequencer that drives the 2x2 max-pool post-process stage. On a start pulse it walks one feature map stored row-major in the post-process buffer and fetches the four pixels of each non-overlapping 2x2 window through a 1-cycle-latency read port. It then presents them, with the window's output index, as a single enable beat to the max-pool datapath, and signals done once every window has been accepted.

## Interface
Parameters:
- IN_W, 24, input map width in pixels. An odd width drops the last column.
- IN_H, 24, input map height in pixels. An odd height drops the last row.
- ADDR_W, 10, buffer address width.
- Legal only if (IN_W/2)*(IN_H/2) <= 512, so the index fits 9 bits.

Ports:
- clk  in  1  clock. One clock domain; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  address of map pixel (0,0); latched when start is accepted.
- busy  out  1  high from the first read through the last accepted beat.
- done  out  1  one-cycle pulse after the final beat is accepted.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  8 signed  buffer data; valid the cycle after rd_en.
- pool_en  out  1  window beat valid; drives the max-pool enable.
- out_ready  in  1  downstream accept. A beat transfers when pool_en && out_ready.
- pool_iter  out  9  output index = r*(IN_W/2)+c.
- pool_d0..pool_d3  out  8 signed each  top-left, top-right, bottom-left, bottom-right pixels.

## Operation
- States: IDLE, RD0, RD1, RD2, RD3, LAST, EMIT, DONE.
- IDLE -> RD0 on start. Latch base_addr and clear the window counters r=c=0.
- RDk, k=0..3: rd_en=1.
  - rd_addr = base + (2r)*IN_W + 2c + {0, 1, IN_W, IN_W+1}[k].
  - Address arithmetic is modulo 2^ADDR_W.
- Capture rule: rd_data is captured into pool_d(k-1) in RD1..RD3, and into pool_d3 in LAST.
- LAST -> EMIT unconditionally. rd_en=0 in both LAST and EMIT.
- EMIT: pool_en=1, with pool_iter and pool_d0..3 stable.
  - While out_ready=0, stay in EMIT and hold all beat outputs.
  - On handshake, advance c. When c wraps at IN_W/2-1, set c=0 and advance r.
  - If the handshake was the last window, go to DONE; otherwise go to RD0.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start outside IDLE is ignored, as is a start coinciding with DONE.
- rst at any state: next cycle is IDLE with all outputs at reset values. No done is emitted and no partial beat is produced.
- Reset values: busy 0, done 0, rd_en 0, rd_addr 0, pool_en 0, pool_iter 0, pool_d0..3 0.
- Signed data passes through unmodified; the controller does no arithmetic on pixels.

## Timing
- All outputs are registered.
- start sampled at edge T: rd_en=1 with the RD0 address in cycle T+1, reads in T+1..T+4, pool_en=1 in T+6.
- With out_ready held high, one window takes 6 cycles and there is no overlap between windows.
- The first read of the next window occurs in the cycle after the handshake.
- Total, out_ready high: the last beat is in cycle T+6*N, where N=(IN_W/2)*(IN_H/2). done is in T+6*N+1.
- Stall: each out_ready=0 cycle in EMIT adds exactly one cycle. No read is issued while stalled.
- busy is 1 from cycle T+1 through the final EMIT cycle inclusive.

## Structure
- Shared package/header holds:
  - the state encoding localparams;
  - the pool index width of 9;
  - the data width of 8;
  - OUT_W=IN_W/2 and OUT_H=IN_H/2 derivation.
- One natural sub-module: maxpool_win_addr_gen. It holds the r/c counters, the last-window flag, the row-base accumulator and the 4-offset address mux. The parent keeps the FSM and data capture.

## Test plan
- 4x4 map, base 0, buffer[i]=i, out_ready=1 -> 4 beats:
  - iter 0, d=(0,1,4,5);
  - iter 1, d=(2,3,6,7);
  - iter 2, d=(8,9,12,13);
  - iter 3, d=(10,11,14,15);
  - pool_en in T+6, T+12, T+18, T+24; done in T+25.
- Default 24x24, base 100, random signed data -> 144 beats with iter 0..143 in order. Each beat's four values match the golden 2x2 window, and done occurs exactly once at T+865.
- out_ready low for 3 cycles in beat 1 -> beat outputs held constant and rd_en=0 while stalled; done delayed by exactly 3 cycles.
- start re-pulsed while busy, and start asserted in the DONE cycle -> both ignored; beat count and done timing unchanged.
- rst asserted in RD2 of window 5 -> next cycle all outputs 0 and state IDLE. A subsequent start restarts at iter 0 with no done from the aborted run.
- 5x5 map (odd dimensions) with base near 2^ADDR_W-1 -> 4 beats. Column 4 and row 4 are never read, and addresses wrap modulo 2^ADDR_W.
